// File: rtl/p2_pkg.sv
// p2_pkg: constants and state type shared by the p2 pipeline hazard logic.
package p2_pkg;

    localparam logic [2:0] TYPE_BUBBLE = 3'd7;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_RTYPE    = 7'b0110011;
    localparam logic [6:0] F7_MULDIV   = 7'b0000001;

    typedef enum logic {
        RUN  = 1'b0,
        MDIV = 1'b1
    } hz_state_t;

endpackage

// File: rtl/p2_hazard_detect.sv
// p2_hazard_detect: combinational load-use and multi-cycle M-op detection against ID/EX.
// Build option HAZARD_MULDIV_EN: when undefined, is_md is held at 0.
module p2_hazard_detect
    import p2_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [2:0] ex_type,
    input  logic [6:0] ex_opcode,
    input  logic [6:0] ex_funct7,
    input  logic [4:0] ex_rd,
    output logic       load_use,
    output logic       is_md
);

    logic ex_valid;
    logic rs1_hit;
    logic rs2_hit;

    assign ex_valid = (ex_type != TYPE_BUBBLE);
    assign rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);

    // x0 is never a real destination, so a load into it cannot create a hazard
    assign load_use = ex_valid && (ex_opcode == OP_LOAD) && (ex_rd != '0)
                      && (rs1_hit || rs2_hit);

`ifdef HAZARD_MULDIV_EN
    assign is_md = ex_valid && (ex_opcode == OP_RTYPE) && (ex_funct7 == F7_MULDIV);
`else
    logic unused_funct7;
    assign unused_funct7 = ^ex_funct7;
    assign is_md         = 1'b0;
`endif

endmodule

// File: rtl/p2_hazard_ctrl.sv
// p2_hazard_ctrl: stall/flush control for PC, IF/ID and ID/EX of the 5-stage core.
// Build option HAZARD_MULDIV_EN enables the multi-cycle mul/div freeze (MDIV state).
module p2_hazard_ctrl
    import p2_pkg::*;
#(
    parameter int unsigned MULDIV_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [2:0] ex_type,
    input  logic [6:0] ex_opcode,
    input  logic [6:0] ex_funct7,
    input  logic [4:0] ex_rd,
    input  logic       ex_branch_taken,
    input  logic       mem_busy,
    output logic       pc_stall,
    output logic       ifid_stall,
    output logic       ifid_flush,
    output logic       idex_stall,
    output logic       idex_flush,
    output logic       muldiv_busy
);

    logic load_use;
    logic is_md;
    logic md_freeze;

    p2_hazard_detect u_detect (
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .ex_type    (ex_type),
        .ex_opcode  (ex_opcode),
        .ex_funct7  (ex_funct7),
        .ex_rd      (ex_rd),
        .load_use   (load_use),
        .is_md      (is_md)
    );

`ifdef HAZARD_MULDIV_EN
    // The detect cycle counts as the first freeze cycle, hence the -2 load.
    localparam logic [3:0] CNT_LOAD = 4'(MULDIV_CYCLES - 2);

    hz_state_t  state;
    hz_state_t  state_next;
    logic [3:0] cnt;
    logic [3:0] cnt_next;
    logic       done;
    logic       done_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            done  <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        done_next  = done;
        case (state)
            RUN: begin
                if (!mem_busy) begin
                    if (is_md && !done) begin
                        state_next = MDIV;
                        cnt_next   = CNT_LOAD;
                    end
                    // done marks the finished op still sitting in EX; it leaves now
                    if (done) begin
                        done_next = 1'b0;
                    end
                end
            end
            MDIV: begin
                if (!mem_busy) begin
                    if (cnt == '0) begin
                        state_next = RUN;
                        done_next  = 1'b1;
                    end else begin
                        cnt_next = cnt - 4'd1;
                    end
                end
            end
            default: state_next = RUN;
        endcase
    end

    assign md_freeze = ((state == RUN) && is_md && !done) || (state == MDIV);
`else
    logic unused_cfg;
    assign unused_cfg = ^{clock, 4'(MULDIV_CYCLES)};
    assign md_freeze  = 1'b0;
`endif

    // Priority chain: a freeze of any kind masks every flush request.
    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_stall  = 1'b0;
        idex_flush  = 1'b0;
        muldiv_busy = 1'b0;
        if (reset) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (mem_busy) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_stall = 1'b1;
        end else if (md_freeze) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            muldiv_busy = 1'b1;
        end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
        end
    end

endmodule

// File: tb/tb_p2_hazard_ctrl.sv
// tb_p2_hazard_ctrl: vector table, hand sequences and random run against a reference model.
// Expectations follow whether HAZARD_MULDIV_EN is defined for the build.
module tb_p2_hazard_ctrl;

    localparam int unsigned N = 4;
`ifdef HAZARD_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    // output vector order: {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, muldiv_busy}
    localparam logic [5:0] O_NONE  = 6'b000000;
    localparam logic [5:0] O_FLUSH = 6'b001010;
    localparam logic [5:0] O_MEM   = 6'b110100;
    localparam logic [5:0] O_MD    = 6'b110101;
    localparam logic [5:0] O_LU    = 6'b110010;
    localparam logic [5:0] O_MDX   = MD_EN ? O_MD : O_NONE;

    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] OPI = 7'b0010011;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2;
    logic [2:0] ex_type;
    logic [6:0] ex_opcode, ex_funct7;
    logic       ex_branch_taken, mem_busy;
    logic       pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, muldiv_busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    p2_hazard_ctrl #(.MULDIV_CYCLES(N)) dut (
        .clock           (clk),
        .reset           (rst),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_type         (ex_type),
        .ex_opcode       (ex_opcode),
        .ex_funct7       (ex_funct7),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .mem_busy        (mem_busy),
        .pc_stall        (pc_stall),
        .ifid_stall      (ifid_stall),
        .ifid_flush      (ifid_flush),
        .idex_stall      (idex_stall),
        .idex_flush      (idex_flush),
        .muldiv_busy     (muldiv_busy)
    );

    // Reference model: remaining freeze cycles of the current M-op and whether it was served.
    int m_rem    = 0;
    bit m_served = 1'b0;

    function automatic bit ref_is_md();
        return MD_EN && (ex_type != 3'd7) && (ex_opcode == RT) && (ex_funct7 == 7'b0000001);
    endfunction

    function automatic bit ref_load_use();
        return (ex_type != 3'd7) && (ex_opcode == LD) && (ex_rd != 5'd0) &&
               ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    endfunction

    function automatic logic [5:0] ref_out();
        bit freeze;
        freeze = (m_rem > 0) || (ref_is_md() && !m_served);
        if (rst)                  return O_FLUSH;
        else if (mem_busy)        return O_MEM;
        else if (freeze)          return O_MD;
        else if (ex_branch_taken) return O_FLUSH;
        else if (ref_load_use())  return O_LU;
        else                      return O_NONE;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_rem    <= 0;
            m_served <= 1'b0;
        end else if (!mem_busy) begin
            if (m_rem > 0) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) m_served <= 1'b1;
            end else if (ref_is_md() && !m_served) begin
                m_rem <= int'(N) - 1;
            end else begin
                m_served <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [5:0] exp);
        logic [5:0] act;
        act = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, muldiv_busy};
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [2:0] typ,
                         input logic [6:0] op, input logic [6:0] f7, input logic [4:0] rd,
                         input logic br, input logic mb);
        rst = r; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
        ex_type = typ; ex_opcode = op; ex_funct7 = f7; ex_rd = rd;
        ex_branch_taken = br; mem_busy = mb;
    endtask

    // one cycle: drive after the falling edge, sample 1 time unit later
    task automatic step(input string name, input logic [5:0] exp, input logic r,
                        input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                        input logic u2, input logic [2:0] typ, input logic [6:0] op,
                        input logic [6:0] f7, input logic [4:0] rd, input logic br,
                        input logic mb);
        @(negedge clk);
        drive(r, rs1, u1, rs2, u2, typ, op, f7, rd, br, mb);
        #1;
        check(name, exp);
    endtask

    typedef struct {
        string      name;
        logic       r;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [2:0] typ;
        logic [6:0] op;
        logic [6:0] f7;
        logic [4:0] rd;
        logic       br;
        logic       mb;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{"lu_rs1",      0, 5, 1, 1, 1, 0, LD,  0,    5, 0, 0, O_LU};
        vecs[1]  = '{"lu_rd0",      0, 0, 1, 1, 1, 0, LD,  0,    0, 0, 0, O_NONE};
        vecs[2]  = '{"br_over_lu",  0, 5, 1, 1, 1, 0, LD,  0,    5, 1, 0, O_FLUSH};
        vecs[3]  = '{"lu_rs2",      0, 2, 1, 9, 1, 1, LD,  0,    9, 0, 0, O_LU};
        vecs[4]  = '{"lu_unused",   0, 5, 0, 1, 1, 0, LD,  0,    5, 0, 0, O_NONE};
        vecs[5]  = '{"lu_bubble",   0, 5, 1, 1, 1, 7, LD,  0,    5, 0, 0, O_NONE};
        vecs[6]  = '{"alu_no_lu",   0, 5, 1, 1, 1, 0, RT,  0,    5, 0, 0, O_NONE};
        vecs[7]  = '{"mem_over_lu", 0, 5, 1, 1, 1, 0, LD,  0,    5, 0, 1, O_MEM};
        vecs[8]  = '{"mem_over_br", 0, 0, 0, 0, 0, 0, OPI, 0,    3, 1, 1, O_MEM};
        vecs[9]  = '{"br_only",     0, 0, 0, 0, 0, 0, OPI, 0,    3, 1, 0, O_FLUSH};
        vecs[10] = '{"rst_over_lu", 1, 5, 1, 1, 1, 0, LD,  0,    5, 0, 1, O_FLUSH};

        drive(1, 0, 0, 0, 0, 7, 0, 0, 0, 1, 0);
        @(negedge clk);
        #1;
        check("reset_state", O_FLUSH);

        foreach (vecs[i])
            step(vecs[i].name, vecs[i].exp, vecs[i].r, vecs[i].rs1, vecs[i].u1, vecs[i].rs2,
                 vecs[i].u2, vecs[i].typ, vecs[i].op, vecs[i].f7, vecs[i].rd, vecs[i].br,
                 vecs[i].mb);

        // load-use stalls exactly once: the inserted bubble clears the hazard
        step("lu_c0", O_LU,   0, 5, 1, 1, 1, 0, LD, 0, 5, 0, 0);
        step("lu_c1", O_NONE, 0, 5, 1, 1, 1, 7, LD, 0, 5, 0, 0);

        // mul held in EX: N freeze cycles, then no retrigger
        for (int unsigned i = 0; i < N + 1; i++)
            step($sformatf("mul_c%0d", i), (i < N) ? O_MDX : O_NONE,
                 0, 1, 1, 2, 1, 0, RT, 7'b0000001, 7, 0, 0);
        step("mul_after", O_NONE, 0, 1, 1, 2, 1, 7, 0, 0, 0, 0, 0);

        // two mem_busy cycles inside MDIV stretch the freeze to 6 cycles
        begin
            logic [5:0] e_md[7];
            logic       mb_pat[7];
            e_md   = '{O_MDX, O_MDX, O_MEM, O_MEM, O_MDX, O_MDX, O_NONE};
            mb_pat = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
            for (int i = 0; i < 7; i++)
                step($sformatf("mdmem_c%0d", i), e_md[i], 0, 1, 1, 2, 1, 0, RT, 7'b0000001,
                     7, 0, mb_pat[i]);
        end
        step("mdmem_after", O_NONE, 0, 1, 1, 2, 1, 7, 0, 0, 0, 0, 0);

        // reset in the 2nd MDIV cycle leaves no residual freeze
        step("mdrst_c0", O_MDX,   0, 1, 1, 2, 1, 0, RT, 7'b0000001, 7, 0, 0);
        step("mdrst_c1", O_MDX,   0, 1, 1, 2, 1, 0, RT, 7'b0000001, 7, 0, 0);
        step("mdrst_c2", O_FLUSH, 1, 1, 1, 2, 1, 0, RT, 7'b0000001, 7, 0, 0);
        step("mdrst_c3", O_FLUSH, 0, 1, 1, 2, 1, 7, 0, 0, 0, 1, 0);
        step("mdrst_c4", O_MDX,   0, 1, 1, 2, 1, 0, RT, 7'b0000001, 7, 0, 0);
        step("mdrst_clr", O_FLUSH, 1, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0);

        // randomized run against the reference model
        for (int i = 0; i < 3000; i++) begin
            int unsigned sel;
            @(negedge clk);
            sel = $urandom_range(0, 9);
            rst             = ($urandom_range(0, 99) < 2);
            id_rs1          = 5'($urandom_range(0, 3));
            id_rs2          = 5'($urandom_range(0, 3));
            id_use_rs1      = 1'($urandom_range(0, 1));
            id_use_rs2      = 1'($urandom_range(0, 1));
            ex_type         = 3'($urandom_range(0, 7));
            ex_opcode       = (sel < 4) ? LD : ((sel < 8) ? RT : OPI);
            ex_funct7       = ($urandom_range(0, 1) == 1) ? 7'b0000001 : 7'($urandom_range(0, 127));
            ex_rd           = 5'($urandom_range(0, 3));
            ex_branch_taken = ($urandom_range(0, 99) < 15);
            mem_busy        = ($urandom_range(0, 99) < 20);
            #1;
            check($sformatf("rand_%0d", i), ref_out());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/p2_hazard_ctrl.md
# p2_hazard_ctrl

Pipeline hazard controller for the 5-stage core. Watches the instruction in decode and the instruction held in the ID/EX register. Drives the stall and flush controls of PC, IF/ID and ID/EX to handle:
- load-use hazards,
- taken-branch flushes,
- data-memory wait states,
- multi-cycle multiply/divide occupancy (optional).

Sits beside the ID/EX register. `idex_flush` drives that register's `reset` input (inserts a type-7 bubble); `idex_stall` drives its `stall` input.

## Interface
- `MULDIV_CYCLES`, default 4: EX occupancy of an M-extension op, in freeze cycles; legal range 2..15.
- `clock`  in  1  Single clock for the block; all state updates on rising edge.
- `reset`  in  1  Synchronous, active-high reset.
- `id_rs1`, `id_rs2`  in  5 each  Source register indices of the instruction in decode.
- `id_use_rs1`, `id_use_rs2`  in  1 each  Decode instruction actually reads that source.
- `ex_type`  in  3  ID/EX `type_out`; value 7 means bubble/invalid.
- `ex_opcode`  in  7  ID/EX `opcode_out`.
- `ex_funct7`  in  7  ID/EX `funct7_out`.
- `ex_rd`  in  5  ID/EX `rd_out`.
- `ex_branch_taken`  in  1  EX resolved a taken branch or jump this cycle.
- `mem_busy`  in  1  Data memory not ready; whole pipeline must hold.
- `pc_stall`  out  1  Hold PC.
- `ifid_stall`  out  1  Hold IF/ID.
- `ifid_flush`  out  1  Clear IF/ID.
- `idex_stall`  out  1  Hold ID/EX.
- `idex_flush`  out  1  Load a bubble into ID/EX.
- `muldiv_busy`  out  1  Multi-cycle op occupying EX.

## Operation
- `ex_valid` = (`ex_type` != 7).
- `load_use` = `ex_valid` & (`ex_opcode` == 7'b0000011) & (`ex_rd` != 0) & ((`id_use_rs1` & `id_rs1` == `ex_rd`) | (`id_use_rs2` & `id_rs2` == `ex_rd`)).
- `is_md` = `ex_valid` & (`ex_opcode` == 7'b0110011) & (`ex_funct7` == 7'b0000001).
- State machine states: RUN, MDIV.
- Internal registers: 4-bit down-counter `cnt`; `done` flag.
- `md_freeze` = (RUN & `is_md` & !`done`) | MDIV.
- Outputs are combinational from state and inputs. Rules are evaluated in strict priority; the first match wins and all unlisted outputs are 0:
  1. `reset`: `ifid_flush` = `idex_flush` = 1.
  2. `mem_busy`: `pc_stall` = `ifid_stall` = `idex_stall` = 1.
  3. `md_freeze`: `pc_stall` = `ifid_stall` = `idex_stall` = 1 and `muldiv_busy` = 1.
  4. `ex_branch_taken`: `ifid_flush` = `idex_flush` = 1.
  5. `load_use`: `pc_stall` = `ifid_stall` = 1 and `idex_flush` = 1.
- All flushes are suppressed while any freeze is active. A branch held in EX during a freeze flushes on the first unfrozen cycle.
- RUN transitions:
  - RUN & `is_md` & !`done` & !`mem_busy`: go to MDIV, load `cnt` = `MULDIV_CYCLES`-2.
  - If `mem_busy` is also high, stay in RUN; the entry retries the next cycle.
- MDIV transitions:
  - When !`mem_busy`: if `cnt` == 0, go to RUN and set `done`=1; otherwise decrement `cnt`.
  - When `mem_busy`: hold `cnt` and state.
- `done` handling:
  - Cleared on any RUN cycle in which `mem_busy` = 0 and `done` = 1 (the instruction leaves EX).
  - Prevents the same instruction from re-triggering.
- `reset` mid-MDIV: returns to RUN with `cnt` = 0 and `done` = 0 on the next edge; no residual freeze.

## Timing
- Load-use:
  - Exactly 1 stall cycle.
  - The bubble makes `load_use` false on the following cycle, so no state is held.
- Branch: flush in the same cycle `ex_branch_taken` is high; 2-instruction penalty.
- MUL/DIV:
  - Freeze is asserted for exactly `MULDIV_CYCLES` consecutive cycles without `mem_busy`: the detect cycle plus `MULDIV_CYCLES`-1 MDIV cycles.
  - Each `mem_busy` cycle during this period extends the freeze by 1.
- Reset values: state RUN, `cnt` 0, `done` 0. While `reset` is high: `ifid_flush` = `idex_flush` = 1 and all other outputs 0.

## Configuration
- `HAZARD_MULDIV_EN`, defined:
  - Implements MDIV, `cnt`, `done` and `muldiv_busy`.
- `HAZARD_MULDIV_EN`, undefined:
  - `is_md` is forced to 0 and the state machine is RUN-only.
  - `muldiv_busy` is tied to 0; the port remains.
  - `MULDIV_CYCLES` is ignored.

## Structure
- Shared package `p2_pkg` holds:
  - `TYPE_BUBBLE` = 3'd7;
  - `OP_LOAD` = 7'b0000011;
  - `OP_RTYPE` = 7'b0110011;
  - `F7_MULDIV` = 7'b0000001;
  - state enum {RUN, MDIV}.
- One sub-module: `p2_hazard_detect`, a purely combinational unit producing `load_use` and `is_md`. All sequencing stays in the top.

## Test plan
- Load `x5` in EX (`ex_opcode` 0000011, `ex_rd` 5); decode `add x6,x5,x1` (`id_rs1` 5, `id_use_rs1` 1):
  - `pc_stall` = `ifid_stall` = `idex_flush` = 1 for 1 cycle.
  - Same scenario with `ex_rd` = 0: no stall.
- `ex_branch_taken` = 1 together with `load_use`: only `ifid_flush` = `idex_flush` = 1, with no stall.
- `MULDIV_CYCLES` = 4, mul (funct7 0000001) enters EX: stalls and `muldiv_busy` = 1 for exactly 4 cycles, then 0; the op does not retrigger.
- `mem_busy` high for 2 cycles during MDIV: freeze lasts 6 cycles total; `cnt` held during `mem_busy`.
- `reset` asserted in the 2nd MDIV cycle:
  - The following cycle is RUN with no freeze.
  - While `reset` is high: `ifid_flush` = `idex_flush` = 1.
- Build without `HAZARD_MULDIV_EN`, same mul: no stall; `muldiv_busy` stays 0.
